// File: rtl/reg_file_cmd_seq.sv
// Command sequencer for the eight-entry register file: buffers host
// commands in a FIFO and replays them as single-cycle WEN/OEN pulses.
module reg_file_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic                   CMD_RW,
  input  logic [AW-1:0]          CMD_ADDR,
  input  logic [DW-1:0]          CMD_DATA,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic [DW-1:0]          RSP_DATA,
  output logic [AW-1:0]          RSP_ADDR,
  output logic                   WEN,
  output logic                   OEN,
  output logic [AW-1:0]          ADDR,
  output logic [DW-1:0]          DIN,
  input  logic [DW-1:0]          DOUT,
  output logic [$clog2(DEPTH):0] CNT,
  output logic                   BUSY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + AW + DW;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    RSP
  } state_t;

  state_t state, state_d;

  logic [EW-1:0] fifo [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  logic          push, pop;
  logic          head_rw;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  assign CMD_READY = (cnt != CW'(DEPTH));
  assign push      = CMD_VALID && CMD_READY;
  assign CNT       = cnt;
  assign BUSY      = (state != IDLE) || (cnt != '0);

  assign {head_rw, head_addr, head_data} = fifo[rd_ptr];

  // WR dispatches like IDLE so writes can stream one per cycle
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      IDLE, WR: begin
        if (cnt != '0) begin
          pop     = 1'b1;
          state_d = head_rw ? WR : RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD:  state_d = CAP;
      CAP: state_d = RSP;
      RSP: if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (push) fifo[wr_ptr] <= {CMD_RW, CMD_ADDR, CMD_DATA};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WEN  <= 1'b0;
      OEN  <= 1'b0;
      ADDR <= '0;
      DIN  <= '0;
    end else begin
      WEN <= pop && head_rw;
      OEN <= pop && !head_rw;
      if (pop) begin
        ADDR <= head_addr;
        DIN  <= head_data;
      end
    end
  end

  // DOUT was loaded at the edge that ended the OEN cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ADDR  <= '0;
    end else if (state == CAP) begin
      RSP_VALID <= 1'b1;
      RSP_DATA  <= DOUT;
      RSP_ADDR  <= ADDR;
    end else if (state == RSP && RSP_READY) begin
      RSP_VALID <= 1'b0;
    end
  end

endmodule
